// File: rtl/riscv_axi_bus_ctrl.sv
// AXI4 single-master bus controller for the RISC-V fetch and data ports: one single-beat word
// transaction at a time. Define AXI_CTRL_ROUND_ROBIN_EN for round-robin arbitration instead of data priority.
module riscv_axi_bus_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_stall,
  output logic                if_fault,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wmask,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_stall,
  output logic                dm_err,
  output logic [3:0]          aw_id,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic [3:0]          aw_len,
  output logic [2:0]          aw_size,
  output logic [1:0]          aw_burst,
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [3:0]          w_id,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  output logic                w_last,
  output logic                w_valid,
  input  logic                w_ready,
  input  logic [3:0]          b_id,
  input  logic [1:0]          b_resp,
  input  logic                b_valid,
  output logic                b_ready,
  output logic [3:0]          ar_id,
  output logic [ADDR_W-1:0]   ar_addr,
  output logic [3:0]          ar_len,
  output logic [2:0]          ar_size,
  output logic [1:0]          ar_burst,
  output logic                ar_valid,
  input  logic                ar_ready,
  input  logic [3:0]          r_id,
  input  logic [DATA_W-1:0]   r_data,
  input  logic [1:0]          r_resp,
  input  logic                r_last,
  input  logic                r_valid,
  output logic                r_ready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  localparam logic [3:0] IF_ID = 4'b1000;
  localparam logic [3:0] DM_ID = 4'b0000;

  state_t              state, state_nxt;
  logic                grant_dm;
  logic                pick_dm;
  logic                any_req;
  logic [ADDR_W-1:0]   sel_addr;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic                aw_acc, w_acc;
  logic                unused_axi;

  assign any_req  = if_req | dm_req;
  assign sel_addr = pick_dm ? dm_addr : if_addr;

`ifdef AXI_CTRL_ROUND_ROBIN_EN
  // On a tie the requester that was not served last wins; lone requesters always win.
  logic last_dm;
  assign pick_dm = dm_req & (~if_req | ~last_dm);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_dm <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_dm <= pick_dm;
    end
  end
`else
  assign pick_dm = dm_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = (pick_dm && dm_we) ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        ar_valid = 1'b1;
        if (ar_ready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        r_ready = 1'b1;
        if (r_valid) state_nxt = DONE;
      end
      // AW and W complete independently; leave once both have been accepted.
      WR_REQ: begin
        aw_valid = ~aw_acc;
        w_valid  = ~w_acc;
        if ((aw_acc || aw_ready) && (w_acc || w_ready)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        b_ready = 1'b1;
        if (b_valid) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_dm <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      aw_acc   <= 1'b0;
      w_acc    <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      if_fault <= 1'b0;
      dm_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_dm <= pick_dm;
            addr_q   <= {sel_addr[ADDR_W-1:2], 2'b00};
            wdata_q  <= dm_wdata;
            wmask_q  <= dm_wmask;
          end
        end
        WR_REQ: begin
          if (state_nxt == WR_RESP) begin
            aw_acc <= 1'b0;
            w_acc  <= 1'b0;
          end else begin
            if (aw_valid && aw_ready) aw_acc <= 1'b1;
            if (w_valid && w_ready)   w_acc  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (r_valid) begin
            if (grant_dm) begin
              dm_rdata <= r_data;
              dm_err   <= (r_resp != 2'b00);
            end else begin
              if_rdata <= r_data;
              if_fault <= (r_resp != 2'b00);
            end
          end
        end
        WR_RESP: begin
          if (b_valid) dm_err <= (b_resp != 2'b00);
        end
        // Error flags are only meaningful during DONE.
        DONE: begin
          if_fault <= 1'b0;
          dm_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign if_stall = if_req & ~(state == DONE && !grant_dm);
  assign dm_stall = dm_req & ~(state == DONE && grant_dm);

  assign ar_id    = grant_dm ? DM_ID : IF_ID;
  assign ar_addr  = addr_q;
  assign ar_len   = 4'd0;
  assign ar_size  = 3'b010;
  assign ar_burst = 2'b00;
  assign aw_id    = grant_dm ? DM_ID : IF_ID;
  assign aw_addr  = addr_q;
  assign aw_len   = 4'd0;
  assign aw_size  = 3'b010;
  assign aw_burst = 2'b00;
  assign w_id     = aw_id;
  assign w_data   = wdata_q;
  assign w_strb   = wmask_q;
  assign w_last   = 1'b1;

  // Response IDs and r_last carry no information with a single outstanding beat.
  assign unused_axi = ^{b_id, r_id, r_last, sel_addr[1:0]};

endmodule

// File: tb/tb_riscv_axi_bus_ctrl.sv
// Self-checking bench for riscv_axi_bus_ctrl: table-driven single transactions against a
// configurable-wait slave, plus arbitration and asynchronous reset sequences.
module tb_riscv_axi_bus_ctrl;

  logic        clk, reset;
  logic        if_req, if_stall, if_fault;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_stall, dm_err;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wmask;
  logic [3:0]  aw_id, aw_len, w_id, b_id, ar_id, ar_len, r_id;
  logic [31:0] aw_addr, w_data, ar_addr, r_data;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
  logic [3:0]  w_strb;

  int checks, errors;
  int ar_wait, r_wait, aw_wait, w_wait, b_wait;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic [31:0] cfg_rdata;
  logic [1:0]  cfg_resp;

  typedef struct {
    string       name;
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          ar_w, r_w, aw_w, w_w, b_w;
    logic [31:0] sdata;
    logic [1:0]  sresp;
    logic [31:0] exp_addr;
    logic [3:0]  exp_id;
    logic [3:0]  exp_strb;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_done;
    int          exp_vcyc;
  } vec_t;

  vec_t vecs[7];

  riscv_axi_bus_ctrl dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall), .if_fault(if_fault),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wmask(dm_wmask),
    .dm_rdata(dm_rdata), .dm_stall(dm_stall), .dm_err(dm_err),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_id(w_id), .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Slave responds with ready/valid after a configurable number of wait cycles per channel.
  task automatic slaveStep();
    if (ar_valid) begin ar_ready = (ar_cnt == ar_wait); ar_cnt = ar_ready ? 0 : ar_cnt + 1; end
    else begin ar_ready = 1'b0; ar_cnt = 0; end
    if (aw_valid) begin aw_ready = (aw_cnt == aw_wait); aw_cnt = aw_ready ? 0 : aw_cnt + 1; end
    else begin aw_ready = 1'b0; aw_cnt = 0; end
    if (w_valid) begin w_ready = (w_cnt == w_wait); w_cnt = w_ready ? 0 : w_cnt + 1; end
    else begin w_ready = 1'b0; w_cnt = 0; end
    if (r_ready) begin
      r_valid = (r_cnt == r_wait);
      r_cnt   = r_valid ? 0 : r_cnt + 1;
      r_data  = r_valid ? cfg_rdata : 32'h0;
      r_resp  = r_valid ? cfg_resp : 2'b00;
    end else begin
      r_valid = 1'b0; r_cnt = 0; r_data = 32'h0; r_resp = 2'b00;
    end
    if (b_ready) begin
      b_valid = (b_cnt == b_wait);
      b_cnt   = b_valid ? 0 : b_cnt + 1;
      b_resp  = b_valid ? cfg_resp : 2'b00;
    end else begin
      b_valid = 1'b0; b_cnt = 0; b_resp = 2'b00;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    slaveStep();
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    int          done_c = -1;
    int          vcyc = 0;
    logic        stable = 1'b1;
    logic        seen = 1'b0, wseen = 1'b0;
    logic [31:0] addr0 = 0, data0 = 0, const0 = 0, rdata_done = 0;
    logic [3:0]  id0 = 0, strb0 = 0;
    logic        err_done = 1'b0, err_after = 1'b1;
    ar_wait = v.ar_w; r_wait = v.r_w; aw_wait = v.aw_w; w_wait = v.w_w; b_wait = v.b_w;
    cfg_rdata = v.sdata; cfg_resp = v.sresp;
    if_addr = v.addr; dm_addr = v.addr; dm_we = v.we; dm_wdata = v.wdata; dm_wmask = v.wmask;
    if_req = ~v.is_dm; dm_req = v.is_dm;
    for (int c = 1; c <= 60 && done_c < 0; c++) begin
      tick();
      if (v.we) begin
        if (aw_valid) begin
          vcyc++;
          if (!seen) begin
            addr0 = aw_addr; id0 = aw_id;
            const0 = 32'({aw_len, aw_size, aw_burst, w_last, w_id});
            seen = 1'b1;
          end else if (aw_addr !== addr0 || aw_id !== id0) stable = 1'b0;
        end
        if (w_valid) begin
          if (!wseen) begin data0 = w_data; strb0 = w_strb; wseen = 1'b1; end
          else if (w_data !== data0 || w_strb !== strb0) stable = 1'b0;
        end
      end else if (ar_valid) begin
        vcyc++;
        if (!seen) begin
          addr0 = ar_addr; id0 = ar_id;
          const0 = 32'({ar_len, ar_size, ar_burst});
          seen = 1'b1;
        end else if (ar_addr !== addr0 || ar_id !== id0) stable = 1'b0;
      end
      if ((v.is_dm ? dm_stall : if_stall) == 1'b0) begin
        done_c     = c;
        err_done   = v.is_dm ? dm_err : if_fault;
        rdata_done = v.is_dm ? dm_rdata : if_rdata;
        if_req = 1'b0; dm_req = 1'b0;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    err_after = v.is_dm ? dm_err : if_fault;
    checkOutput({v.name, "_done_cycle"}, 32'(done_c), 32'(v.exp_done));
    checkOutput({v.name, "_addr"}, addr0, v.exp_addr);
    checkOutput({v.name, "_id"}, 32'(id0), 32'(v.exp_id));
    checkOutput({v.name, "_valid_cycles"}, 32'(vcyc), 32'(v.exp_vcyc));
    checkOutput({v.name, "_stable"}, 32'(stable), 32'h1);
    checkOutput({v.name, "_err_done"}, 32'(err_done), 32'(v.exp_err));
    checkOutput({v.name, "_err_after"}, 32'(err_after), 32'h0);
    if (v.we) begin
      checkOutput({v.name, "_wconst"}, const0, 32'({4'd0, 3'b010, 2'b00, 1'b1, v.exp_id}));
      checkOutput({v.name, "_wdata"}, data0, v.exp_data);
      checkOutput({v.name, "_wstrb"}, 32'(strb0), 32'(v.exp_strb));
    end else begin
      checkOutput({v.name, "_rconst"}, const0, 32'({4'd0, 3'b010, 2'b00}));
      checkOutput({v.name, "_rdata"}, rdata_done, v.exp_data);
    end
  endtask

  initial begin
    int grants[4];
    int exp_grants[4];
    int ng;
    logic reached;
    checks = 0; errors = 0;
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    cfg_rdata = 0; cfg_resp = 0;
    ar_ready = 0; aw_ready = 0; w_ready = 0; r_valid = 0; b_valid = 0;
    r_data = 0; r_resp = 0; r_last = 1'b1; r_id = 0; b_resp = 0; b_id = 0;
    if_addr = 0; dm_addr = 0; dm_we = 0; dm_wdata = 0; dm_wmask = 0;
    if_req = 1'b1; dm_req = 1'b0;
    reset = 1'b1;

    vecs[0] = '{"fetch_basic", 1'b0, 1'b0, 32'h104, 32'h0, 4'h0, 0, 0, 0, 0, 0,
                32'h00500093, 2'b00, 32'h104, 4'b1000, 4'h0, 32'h00500093, 1'b0, 3, 1};
    vecs[1] = '{"store_aw_first", 1'b1, 1'b1, 32'h2003, 32'hA5A51234, 4'b0010, 0, 0, 0, 2, 0,
                32'h0, 2'b00, 32'h2000, 4'h0, 4'b0010, 32'hA5A51234, 1'b0, 5, 1};
    vecs[2] = '{"load_slverr", 1'b1, 1'b0, 32'h3000, 32'h0, 4'h0, 0, 0, 0, 0, 0,
                32'hDEADBEEF, 2'b10, 32'h3000, 4'h0, 4'h0, 32'hDEADBEEF, 1'b1, 3, 1};
    vecs[3] = '{"load_rwait", 1'b1, 1'b0, 32'h41, 32'h0, 4'h0, 0, 2, 0, 0, 0,
                32'h11112222, 2'b00, 32'h40, 4'h0, 4'h0, 32'h11112222, 1'b0, 5, 1};
    vecs[4] = '{"store_w_first", 1'b1, 1'b1, 32'h10000008, 32'h0BADF00D, 4'hF, 0, 0, 3, 0, 1,
                32'h0, 2'b11, 32'h10000008, 4'h0, 4'hF, 32'h0BADF00D, 1'b1, 7, 4};
    vecs[5] = '{"fetch_arwait", 1'b0, 1'b0, 32'h200, 32'h0, 4'h0, 5, 0, 0, 0, 0,
                32'h00000013, 2'b00, 32'h200, 4'b1000, 4'h0, 32'h00000013, 1'b0, 8, 6};
    vecs[6] = '{"fetch_fault", 1'b0, 1'b0, 32'hFFFFFFFE, 32'h0, 4'h0, 0, 0, 0, 0, 0,
                32'h12345678, 2'b10, 32'hFFFFFFFC, 4'b1000, 4'h0, 32'h12345678, 1'b1, 3, 1};

    // Reset values, with stalls following the requests.
    @(negedge clk); #1;
    checkOutput("rst_valids", 32'({ar_valid, aw_valid, w_valid, r_ready, b_ready}), 32'h0);
    checkOutput("rst_rdata", if_rdata | dm_rdata, 32'h0);
    checkOutput("rst_flags", 32'({if_fault, dm_err}), 32'h0);
    checkOutput("rst_stalls", 32'({if_stall, dm_stall}), 32'h2);
    if_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();

    // Both requesters held high for four transactions.
`ifdef AXI_CTRL_ROUND_ROBIN_EN
    exp_grants = '{1, 0, 1, 0};
`else
    exp_grants = '{1, 1, 1, 1};
`endif
    grants = '{2, 2, 2, 2};
    ng = 0;
    if_addr = 32'h500; dm_addr = 32'h600; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      tick();
      if (!dm_stall) begin grants[ng] = 1; ng++; end
      else if (!if_stall) begin grants[ng] = 0; ng++; end
    end
    if_req = 1'b0; dm_req = 1'b0;
    for (int i = 0; i < 4; i++) checkOutput($sformatf("arb_grant%0d_is_dm", i), 32'(grants[i]), 32'(exp_grants[i]));
    tick();
    tick();

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Reset asserted while the read is waiting in RD_DATA.
    ar_wait = 0; r_wait = 20; cfg_rdata = 32'h77777777; cfg_resp = 2'b00;
    if_addr = 32'h300; if_req = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 10 && !reached; c++) begin
      tick();
      if (r_ready) reached = 1'b1;
    end
    checkOutput("rst_mid_reached_rd_data", 32'(reached), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_ar_r", 32'({ar_valid, r_ready}), 32'h0);
    checkOutput("rst_mid_if_rdata", if_rdata, 32'h0);
    checkOutput("rst_mid_dm_rdata", dm_rdata, 32'h0);
    checkOutput("rst_mid_if_stall", 32'(if_stall), 32'h1);
    if_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkOutput("post_rst_idle", 32'({ar_valid, aw_valid, w_valid, r_ready, b_ready}), 32'h0);
    applyStimulus(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_axi_bus_ctrl.md
# riscv_axi_bus_ctrl

Single-master AXI4 bus controller sitting between the RISC-V core's instruction-fetch and data-memory ports and the external AXI interface. It arbitrates the two core requesters onto one AXI master and issues exactly one single-beat, word-sized transaction at a time. It sequences the AR/R and AW/W/B handshakes with a state machine and returns registered read data plus stall and error indications to the core. ID bit 3 tags instruction traffic (4'b1000); data traffic uses 4'b0000.

## Interface
- ADDR_W, 32, address width (core and AXI)
- DATA_W, 32, data width; fixed at 32 (wmask/strb are DATA_W/8)
- clk  in  1  core/AXI clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr while if_stall=1
- if_addr  in  ADDR_W  fetch address (pc)
- if_rdata  out  DATA_W  fetched instruction, valid when if_req & ~if_stall
- if_stall  out  1  fetch not complete
- if_fault  out  1  access fault, valid with if_rdata
- dm_req, dm_we  in  1  data request / write enable; held while dm_stall=1
- dm_addr  in  ADDR_W; dm_wdata  in  DATA_W; dm_wmask  in  4
- dm_rdata  out  DATA_W; dm_stall  out  1; dm_err  out  1 (load or store error)
- AXI master: aw_id/addr/len/size/burst/valid out, aw_ready in; w_id/data/strb/last/valid out, w_ready in; b_id/resp/valid in, b_ready out; ar_id/addr/len/size/burst/valid out, ar_ready in; r_id/data/resp/last/valid in, r_ready out (widths as AXI3-style: id 4, len 4, size 3, burst 2, resp 2)

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: grant on pending requests; if both are pending, data wins (fixed priority). Latch grantee, address (bits [1:0] forced to 0), wdata, and wmask. Read grant goes to RD_ADDR; data write grant (dm_we=1) goes to WR_REQ. No request: stay.
- RD_ADDR: ar_valid=1, ar_id=grantee tag. On ar_ready go to RD_DATA.
- RD_DATA: r_ready=1. On r_valid, capture r_data into the grantee's rdata register, set fault = (r_resp!=2'b00), then go to DONE.
- WR_REQ: aw_valid and w_valid raised together. Each drops independently after its own handshake; per-channel "accepted" flags track this. Leave when both are accepted (same or different cycles), then go to WR_RESP.
- WR_RESP: b_ready=1. On b_valid, dm_err = (b_resp!=2'b00), then go to DONE.
- DONE: one cycle. The grantee's stall is 0. Return to IDLE; a new request may be granted the following cycle.
- Stalls are combinational: if_stall = if_req & ~(DONE & grant==IF); dm_stall likewise.
- Constant fields: len=0, size=3'b010, burst=2'b00, w_last=1, w_id=aw_id.
- r_id/b_id are not checked; only one transaction is ever outstanding.
- Requester drops its req mid-transaction (e.g. flush): the transaction still completes on AXI, and its result/err is discarded (DONE stall pulse is harmless).
- if_rdata/dm_rdata hold their last captured value until overwritten.

## Timing
- Reset values: all valid/ready outputs 0; if_rdata, dm_rdata 0; if_fault, dm_err 0; state IDLE; accepted flags 0; stalls follow req.
- Read latency with zero-wait slave: request cycle 0 (IDLE) → ar_valid cycle 1 → r accepted cycle 2 → DONE/stall low cycle 3. Each slave wait cycle adds one.
- Write, zero-wait: aw/w valid cycle 1 → b cycle 2 → DONE cycle 3.
- Valid signals never drop before their ready is seen; address and data stay stable while valid.
- if_fault and dm_err are valid only in the DONE cycle; they are cleared on leaving DONE.
- Reset mid-transaction aborts immediately to reset values. The slave must share the reset.

## Configuration
- AXI_CTRL_ROUND_ROBIN_EN: when defined, a last-grant flop (reset to IF) gives a simultaneous IF+DM request to the requester not granted last; a lone requester is always granted. When undefined, data has fixed priority and fetch can starve under back-to-back data traffic.

## Test plan
- Fetch only, zero-wait slave, if_addr=0x0000_0104 → ar_addr=0x104, ar_id=4'b1000, if_stall low in cycle 3 only, if_rdata=r_data=0x0050_0093.
- Store dm_addr=0x2003, wmask=4'b0010, slave accepts aw 2 cycles before w → aw_addr=0x2000, w_strb=4'b0010, aw_id=0, dm_stall released exactly one cycle after the b handshake.
- Load returns r_resp=2'b10 → dm_err=1 and dm_stall=0 in the DONE cycle, dm_err=0 the next cycle.
- IF and DM request together for 4 transactions: without the macro, grants are DM,DM,DM,DM; with AXI_CTRL_ROUND_ROBIN_EN, grants are DM,IF,DM,IF.
- ar_ready held low 5 cycles → ar_valid and ar_addr stable for 6 cycles, if_stall=1 throughout.
- Reset asserted while in RD_DATA → ar_valid=r_ready=0 and if_rdata=0 asynchronously, state IDLE after release.
